// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage RV32I core:
// load-use/control hazard stalls and flushes, EX operand forwarding, multi-cycle unit launch.
module hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MultiE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             mc_done,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mc_start,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int BW = $clog2(MC_TIMEOUT);
  localparam logic [BW-1:0] BUSY_MAX = BW'(MC_TIMEOUT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    state;
  logic [BW-1:0] busy_cnt;
  logic          idle, busy, timeout_hit, mc_stall, lw_stall;

  // MEM result takes priority over WB; x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic we_m, input logic [4:0] rd_m,
                                         input logic we_w, input logic [4:0] rd_w);
    if (we_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (we_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  always_comb begin
    idle        = (state == S_IDLE);
    busy        = (state == S_BUSY);
    timeout_hit = busy && !mc_done && (busy_cnt == BUSY_MAX);
    mc_stall    = (idle && MultiE) || (busy && !mc_done && !timeout_hit);
    lw_stall    = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // NOTE: every output below is assigned on every path, so no latch can be inferred.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    mc_start  = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      StallF    = lw_stall || mc_stall;
      StallD    = lw_stall || mc_stall;
      StallE    = mc_stall;
      FlushM    = mc_stall;
      FlushE    = (lw_stall || PCSrcE) && !mc_stall;
      FlushD    = PCSrcE && !mc_stall;
      mc_start  = idle && MultiE;
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy_cnt    <= '0;
      mc_timeout  <= 1'b0;
      stall_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (MultiE) begin
            state    <= S_BUSY;
            busy_cnt <= '0;
          end
        end
        S_BUSY: begin
          if (mc_done) begin
            state <= S_IDLE;
          end else if (timeout_hit) begin
            state      <= S_IDLE;
            mc_timeout <= 1'b1;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (StallF && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: reset, load-use, forwarding,
// branch flush, multi-cycle launch/hold, watchdog and reset during BUSY.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        LoadE, PCSrcE, MultiE, RegWriteM, RegWriteW, mc_done;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_start, mc_timeout;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] stall_count;
  logic [6:0]  ctl;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.MC_TIMEOUT(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MultiE(MultiE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .RdM(RdM), .RdW(RdW),
    .mc_done(mc_done),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mc_start(mc_start), .mc_timeout(mc_timeout), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Bit order: StallF StallD StallE FlushD FlushE FlushM mc_start
  assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_start};

  // Advance one clock; inputs change 1 ns after the edge, checks happen 1 ns later still.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    LoadE = 0; PCSrcE = 0; MultiE = 0; RegWriteM = 0; RegWriteW = 0; mc_done = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    MultiE = 1; RegWriteM = 1; RdM = 5'd3; Rs1E = 5'd3; Rs2E = 5'd3;
    step(); step();
    settle();
    n_checks++;
    if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL reset_ctl got %b expected %b", ctl, 7'b0000000); end
    n_checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd got %b expected 0000", {ForwardAE, ForwardBE}); end
    n_checks++;
    if (stall_count !== 32'd0 || mc_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_state cnt=%0d to=%b expected 0/0", stall_count, mc_timeout); end
    step();
    rst = 1'b0;
    clear_inputs();
    mc_done = 1;
    settle();
    n_checks++;
    if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL post_reset_idle_done got %b expected %b", ctl, 7'b0000000); end
    step();
    mc_done = 0;
  endtask

  task automatic test_load_use();
    clear_inputs();
    LoadE = 1; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd9;
    settle();
    n_checks++;
    if (ctl !== 7'b1100100) begin n_fail++; $display("FAIL load_use_rs1 got %b expected %b", ctl, 7'b1100100); end
    step();
    clear_inputs();
    RegWriteM = 1; RdM = 5'd5; Rs1E = 5'd5; Rs1D = 5'd1;
    settle();
    n_checks++;
    if (ctl !== 7'b0000000 || ForwardAE !== 2'b10) begin n_fail++; $display("FAIL load_use_after got ctl=%b fa=%b expected 0000000/10", ctl, ForwardAE); end
    step();
    clear_inputs();
    LoadE = 1; RdE = 5'd0; Rs1D = 5'd0;
    settle();
    n_checks++;
    if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL load_x0 got %b expected %b", ctl, 7'b0000000); end
    step();
    clear_inputs();
    LoadE = 1; RdE = 5'd12; Rs1D = 5'd4; Rs2D = 5'd12;
    settle();
    n_checks++;
    if (ctl !== 7'b1100100) begin n_fail++; $display("FAIL load_use_rs2 got %b expected %b", ctl, 7'b1100100); end
    step();
    clear_inputs();
    settle();
    n_checks++;
    if (stall_count !== 32'd2) begin n_fail++; $display("FAIL load_use_count got %0d expected 2", stall_count); end
  endtask

  task automatic test_forward();
    clear_inputs();
    RegWriteM = 1; RegWriteW = 1; RdM = 5'd7; RdW = 5'd7; Rs2E = 5'd7; Rs1E = 5'd8;
    settle();
    n_checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0010) begin n_fail++; $display("FAIL fwd_priority got %b expected 0010", {ForwardAE, ForwardBE}); end
    RegWriteM = 0;
    settle();
    n_checks++;
    if (ForwardBE !== 2'b01) begin n_fail++; $display("FAIL fwd_wb_only got %b expected 01", ForwardBE); end
    RegWriteW = 0;
    settle();
    n_checks++;
    if (ForwardBE !== 2'b00) begin n_fail++; $display("FAIL fwd_no_write got %b expected 00", ForwardBE); end
    RegWriteM = 1; RegWriteW = 1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    settle();
    n_checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin n_fail++; $display("FAIL fwd_x0 got %b expected 0000", {ForwardAE, ForwardBE}); end
    RdM = 5'd7; RdW = 5'd9; Rs1E = 5'd7; Rs2E = 5'd9;
    settle();
    n_checks++;
    if ({ForwardAE, ForwardBE} !== 4'b1001) begin n_fail++; $display("FAIL fwd_split got %b expected 1001", {ForwardAE, ForwardBE}); end
    step();
  endtask

  task automatic test_branch();
    clear_inputs();
    PCSrcE = 1;
    settle();
    n_checks++;
    if (ctl !== 7'b0001100) begin n_fail++; $display("FAIL branch got %b expected %b", ctl, 7'b0001100); end
    step();
    clear_inputs();
    settle();
    n_checks++;
    if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL branch_after got %b expected %b", ctl, 7'b0000000); end
  endtask

  task automatic test_multicycle();
    int bad;
    clear_inputs();
    MultiE = 1;
    settle();
    n_checks++;
    if (ctl !== 7'b1110011) begin n_fail++; $display("FAIL mc_launch got %b expected %b", ctl, 7'b1110011); end
    bad = 0;
    for (int i = 1; i < 8; i++) begin
      step();
      if (ctl !== 7'b1110010) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL mc_hold bad_cycles=%0d expected 0", bad); end
    step();
    mc_done = 1;
    settle();
    n_checks++;
    if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL mc_done_cycle got %b expected %b", ctl, 7'b0000000); end
    step();
    mc_done = 0;
    settle();
    n_checks++;
    if (ctl !== 7'b1110011 || stall_count !== 32'd10) begin n_fail++; $display("FAIL mc_back_to_back got ctl=%b cnt=%0d expected 1110011/10", ctl, stall_count); end
    step();
    n_checks++;
    if (ctl !== 7'b1110010) begin n_fail++; $display("FAIL mc2_hold got %b expected %b", ctl, 7'b1110010); end
    step();
    mc_done = 1;
    settle();
    n_checks++;
    if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL mc2_done got %b expected %b", ctl, 7'b0000000); end
    step();
    clear_inputs();
    settle();
    n_checks++;
    if (stall_count !== 32'd12) begin n_fail++; $display("FAIL mc_count got %0d expected 12", stall_count); end
  endtask

  task automatic test_watchdog();
    int stalled;
    clear_inputs();
    MultiE = 1;
    stalled = 0;
    settle();
    for (int i = 0; i < 64; i++) begin
      if (StallF === 1'b1 && StallE === 1'b1) stalled++;
      step();
    end
    n_checks++;
    if (stalled != 64) begin n_fail++; $display("FAIL wd_stall_cycles got %0d expected 64", stalled); end
    n_checks++;
    if (ctl !== 7'b0000000 || mc_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_release got ctl=%b to=%b expected 0000000/0", ctl, mc_timeout); end
    step();
    MultiE = 0;
    settle();
    n_checks++;
    if (mc_timeout !== 1'b1 || ctl !== 7'b0000000) begin n_fail++; $display("FAIL wd_flag got to=%b ctl=%b expected 1/0000000", mc_timeout, ctl); end
    step();
    MultiE = 1;
    settle();
    n_checks++;
    if (mc_start !== 1'b1) begin n_fail++; $display("FAIL wd_back_idle got mc_start=%b expected 1", mc_start); end
    step();
    MultiE = 1; mc_done = 1;
    settle();
    step();
    clear_inputs();
    settle();
    n_checks++;
    if (mc_timeout !== 1'b1 || stall_count !== 32'd77) begin n_fail++; $display("FAIL wd_sticky got to=%b cnt=%0d expected 1/77", mc_timeout, stall_count); end
  endtask

  task automatic test_reset_mid_busy();
    clear_inputs();
    MultiE = 1;
    settle();
    step(); step(); step();
    rst = 1;
    settle();
    n_checks++;
    if (ctl !== 7'b0000000) begin n_fail++; $display("FAIL rst_busy_ctl got %b expected %b", ctl, 7'b0000000); end
    step();
    rst = 0;
    clear_inputs();
    mc_done = 1;
    settle();
    n_checks++;
    if (ctl !== 7'b0000000 || mc_timeout !== 1'b0 || stall_count !== 32'd0) begin
      n_fail++; $display("FAIL rst_busy_after got ctl=%b to=%b cnt=%0d expected 0000000/0/0", ctl, mc_timeout, stall_count);
    end
    step();
    mc_done = 0;
    MultiE = 1;
    settle();
    n_checks++;
    if (mc_start !== 1'b1 || stall_count !== 32'd0) begin n_fail++; $display("FAIL rst_busy_relaunch got mc_start=%b cnt=%0d expected 1/0", mc_start, stall_count); end
    step();
    mc_done = 1;
    settle();
    step();
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_multicycle();
    test_watchdog();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core. It generates the stall, flush and forwarding controls that drive the IF/ID, ID/EX, EX/MEM pipeline registers and the EX operand muxes. It detects load-use and control hazards. It runs a small FSM that launches a multi-cycle execute unit (iterative mul/div) and holds the front of the pipeline until that unit completes, with a watchdog and a stall-cycle performance counter.

## Interface
- MC_TIMEOUT, 64: maximum BUSY cycles before the watchdog fires (≥2).
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in ID.
- Rs1E, Rs2E, RdE  in  5  source and destination registers of the instruction in EX.
- LoadE  in  1  the EX instruction is a load.
- PCSrcE  in  1  a taken branch or jump resolves in EX.
- MultiE  in  1  the EX instruction needs the multi-cycle unit.
- RegWriteM, RegWriteW  in  1  MEM and WB stages write the register file.
- RdM, RdW  in  5  MEM and WB destination registers.
- mc_done  in  1  the multi-cycle unit has a result this cycle (1-cycle pulse).
- StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX respectively.
- FlushD, FlushE, FlushM  out  1  bubble IF/ID, ID/EX and EX/MEM respectively.
- ForwardAE, ForwardBE  out  2  EX operand select: 00 register file, 01 WB result, 10 MEM ALU result.
- mc_start  out  1  1-cycle launch pulse to the multi-cycle unit.
- mc_timeout  out  1  sticky watchdog error flag.
- stall_count  out  CNT_W  saturating count of cycles with StallF=1.

## Operation

**FSM** (states IDLE, BUSY; reset → IDLE):
- IDLE, MultiE=1 → mc_start=1, go to BUSY, clear busy counter.
- BUSY, mc_done=1 → IDLE.
- BUSY, mc_done=0, busy counter = MC_TIMEOUT-1 → set mc_timeout, go to IDLE (release stall).
- BUSY otherwise → busy counter +1.

**Stall and flush logic:**
- mcStall = (IDLE & MultiE) | (BUSY & ~mc_done & ~timeout_hit).
- lwStall = LoadE & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- StallF = StallD = lwStall | mcStall.
- StallE = mcStall.
- FlushM = mcStall: a bubble enters MEM while EX is held.
- FlushE = (lwStall | PCSrcE) & ~mcStall.
- FlushD = PCSrcE & ~mcStall.
- PCSrcE, LoadE and MultiE are mutually exclusive by decode. If they collide, mcStall wins over everything.

**Forwarding** (same rule for B using Rs2E):
- ForwardAE=10 if RegWriteM & RdM≠0 & RdM==Rs1E.
- Else ForwardAE=01 if RegWriteW & RdW≠0 & RdW==Rs1E.
- Else ForwardAE=00.
- The MEM stage has priority over WB. x0 is never forwarded.

**Multi-cycle unit:**
- The unit latches its forwarded operands on the mc_start cycle. Later forwarding changes while BUSY are irrelevant.
- mc_done in IDLE is ignored.
- A second multi-cycle op arriving in EX the cycle after release starts a fresh IDLE→BUSY sequence.

**Watchdog and counter:**
- mc_timeout is cleared only by rst.
- stall_count increments when StallF=1 and saturates at all-ones.

## Timing
- Reset: during rst=1 and on the following cycle:
  - state IDLE, busy counter 0, mc_timeout 0, stall_count 0.
  - mc_start and all Stall/Flush outputs forced to 0.
  - ForwardAE/ForwardBE are 00 while rst=1.
- Stall, flush and forward outputs are combinational from the inputs and state, in the same cycle.
- mc_start is asserted in the first EX cycle of the multi-cycle op only.
- Stall hold: with mc_done arriving N cycles after mc_start (N≥1), StallF/StallD/StallE are high for N cycles. They are low in the mc_done cycle, and the op advances to MEM at that edge.
- Load-use costs exactly one stall cycle: StallF/StallD and FlushE high for 1 cycle.
- A taken branch costs two flushed slots: FlushD and FlushE high in the PCSrcE cycle.
- Watchdog: with no mc_done, stalls last exactly MC_TIMEOUT cycles, then mc_timeout rises on the next edge.
- Reset mid-BUSY: back to IDLE on the next edge with no mc_start pulse. A late mc_done is ignored.

## Test plan
- Load-use: LoadE=1, RdE=5, Rs1D=5 → StallF=StallD=FlushE=1 for 1 cycle. Then with RdM=5, RegWriteM=1, Rs1E=5 → ForwardAE=10.
- Forward priority and x0: RdM=RdW=7 (both writing), Rs2E=7 → ForwardBE=10. RdM=0, RdW=0, Rs1E=0 → ForwardAE=00.
- Branch: PCSrcE=1 → FlushD=FlushE=1, StallF=0, same cycle.
- Multi-cycle, mc_done 8 cycles after launch:
  - mc_start is a single pulse.
  - StallF/D/E and FlushM are high for 8 cycles and drop in the done cycle.
  - stall_count=8.
  - A back-to-back second op relaunches mc_start the next cycle.
- Watchdog (MC_TIMEOUT=64, mc_done never) → stalls for 64 cycles, mc_timeout=1 and sticky, FSM back to IDLE.
- rst asserted in the 3rd BUSY cycle → all outputs 0, mc_timeout 0, stall_count 0; a subsequent mc_done pulse is ignored.
